crossing_sequencer: RTL and testbench

CROSSING_SEQUENCER -- requirements
Module: crossing_sequencer

---
 rtl/crossing_pkg.sv | 61 ++++++
 rtl/crossing_timer.sv | 26 ++
 rtl/crossing_sequencer.sv | 146 ++++++++++++++
 tb/tb_crossing_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// Shared constants for the level-crossing sequencer: state codes, default
// phase lengths, the registered lamp/barrier output bundle and its decode.
package crossing_pkg;

  // State codes as seen on present_state
  localparam logic [3:0] ST_IDLE   = 4'b0000;
  localparam logic [3:0] ST_BLINK  = 4'b0011;
  localparam logic [3:0] ST_AMBER  = 4'b0100;
  localparam logic [3:0] ST_LOWER  = 4'b0110;
  localparam logic [3:0] ST_CLOSED = 4'b0111;
  localparam logic [3:0] ST_RAISE  = 4'b1010;
  localparam logic [3:0] ST_CLEAR  = 4'b1011;
  localparam logic [3:0] ST_FAULT  = 4'b1111;

  // Default phase lengths in clock cycles
  localparam logic [15:0] T_BLINK_DEF = 16'd50;
  localparam logic [15:0] T_AMBER_DEF = 16'd100;
  localparam logic [15:0] T_CLEAR_DEF = 16'd20;
  localparam logic [15:0] T_WDOG_DEF  = 16'd5000;

  // Output bundle; al is active-low (0 = alarm sounding)
  typedef struct packed {
    logic y;
    logic v;
    logic r;
    logic a;
    logic vint;
    logic al;
    logic b1;
    logic b2;
  } lamps_t;

  // A phase of N cycles loads N-1 so the zero cycle is the last one;
  // a length of 0 degenerates to a single cycle.
  function automatic logic [15:0] load_value(input logic [15:0] cycles);
    return (cycles == 16'd0) ? 16'd0 : cycles - 16'd1;
  endfunction

  // States covered by the watchdog (barriers commanded or in motion)
  function automatic logic is_watched(input logic [3:0] st);
    return (st == ST_LOWER) || (st == ST_CLOSED) || (st == ST_RAISE);
  endfunction

  // Lamp/barrier pattern for each state; unknown codes show the idle pattern
  function automatic lamps_t decode_lamps(input logic [3:0] st);
    lamps_t o;
    o = '{y: 1'b0, v: 1'b1, r: 1'b0, a: 1'b0, vint: 1'b0, al: 1'b1, b1: 1'b0, b2: 1'b0};
    case (st)
      ST_BLINK:  o = '{y: 1'b0, v: 1'b0, r: 1'b0, a: 1'b0, vint: 1'b1, al: 1'b1, b1: 1'b0, b2: 1'b0};
      ST_AMBER:  o = '{y: 1'b0, v: 1'b0, r: 1'b0, a: 1'b1, vint: 1'b0, al: 1'b0, b1: 1'b0, b2: 1'b0};
      ST_LOWER:  o = '{y: 1'b0, v: 1'b0, r: 1'b0, a: 1'b1, vint: 1'b0, al: 1'b0, b1: 1'b1, b2: 1'b1};
      ST_CLOSED: o = '{y: 1'b0, v: 1'b0, r: 1'b1, a: 1'b0, vint: 1'b0, al: 1'b0, b1: 1'b1, b2: 1'b1};
      ST_RAISE:  o = '{y: 1'b1, v: 1'b0, r: 1'b1, a: 1'b0, vint: 1'b0, al: 1'b1, b1: 1'b0, b2: 1'b0};
      ST_CLEAR:  o = '{y: 1'b1, v: 1'b1, r: 1'b0, a: 1'b0, vint: 1'b0, al: 1'b1, b1: 1'b0, b2: 1'b0};
      ST_FAULT:  o = '{y: 1'b0, v: 1'b0, r: 1'b1, a: 1'b0, vint: 1'b0, al: 1'b0, b1: 1'b1, b2: 1'b1};
      default:   o = '{y: 1'b0, v: 1'b1, r: 1'b0, a: 1'b0, vint: 1'b0, al: 1'b1, b1: 1'b0, b2: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/crossing_timer.sv
// Loadable 16-bit down-counter that holds at zero and flags it.
module crossing_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] load_val_i,
  output logic        zero_o
);

  logic [15:0] count_q;

  // Load takes priority; otherwise count down and stick at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != 16'd0)) begin
      count_q <= count_q - 16'd1;
    end
  end

  assign zero_o = (count_q == 16'd0);

endmodule

// File: rtl/crossing_sequencer.sv
// Level-crossing sequencer: green -> blinking -> amber -> barriers down ->
// closed -> barriers up -> clear -> green. All outputs are registered and
// change on the same edge as present_state.
// Optional watchdog: define CROSSING_WATCHDOG_EN to bound the time spent in
// LOWER/CLOSED/RAISE; on expiry the block latches FAULT until reset.
module crossing_sequencer
  import crossing_pkg::*;
#(
  parameter logic [15:0] T_BLINK = T_BLINK_DEF,
  parameter logic [15:0] T_AMBER = T_AMBER_DEF,
  parameter logic [15:0] T_CLEAR = T_CLEAR_DEF,
  parameter logic [15:0] T_WDOG  = T_WDOG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arrive,
  input  logic       depart,
  input  logic       bar_down,
  input  logic       bar_up,
  output logic [3:0] present_state,
  output logic       y,
  output logic       v,
  output logic       r,
  output logic       a,
  output logic       vint,
  output logic       al,
  output logic       b1,
  output logic       b2
);

  logic [3:0]  state_q, state_d;
  lamps_t      lamps_q;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_zero;
  logic        wdog_zero;

  // Phase timer shared by BLINK, AMBER and CLEAR
  crossing_timer u_phase_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .en_i      (1'b1),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

`ifdef CROSSING_WATCHDOG_EN
  logic wdog_load;

  // Arm the watchdog only when entering the guarded region from outside, so
  // a re-arrival from RAISE keeps the running count.
  assign wdog_load = (state_d == ST_LOWER) && !is_watched(state_q);

  crossing_timer u_wdog_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (wdog_load),
    .en_i      (1'b1),
    .load_val_i(load_value(T_WDOG)),
    .zero_o    (wdog_zero)
  );
`else
  logic unused_wdog;
  assign wdog_zero   = 1'b0;
  assign unused_wdog = ^T_WDOG;
`endif

  // Next-state and timer-load decisions
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = 16'd0;
    case (state_q)
      ST_IDLE: begin
        if (arrive) begin
          state_d  = ST_BLINK;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_BLINK);
        end
      end
      ST_BLINK: begin
        if (tmr_zero) begin
          state_d  = ST_AMBER;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_AMBER);
        end
      end
      ST_AMBER: begin
        if (tmr_zero) state_d = ST_LOWER;
      end
      ST_LOWER: begin
        if (bar_down) state_d = ST_CLOSED;
      end
      ST_CLOSED: begin
        if (depart) state_d = ST_RAISE;
      end
      ST_RAISE: begin
        // A new train overrides the raise in progress
        if (arrive) begin
          state_d = ST_LOWER;
        end else if (bar_up) begin
          state_d  = ST_CLEAR;
          tmr_load = 1'b1;
          tmr_val  = load_value(T_CLEAR);
        end
      end
      ST_CLEAR: begin
        if (arrive)        state_d = ST_LOWER;
        else if (tmr_zero) state_d = ST_IDLE;
      end
`ifdef CROSSING_WATCHDOG_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_IDLE;
    endcase
    // Watchdog expiry overrides any transition inside the guarded region
    if (is_watched(state_q) && wdog_zero) begin
      state_d  = ST_FAULT;
      tmr_load = 1'b0;
    end
  end

  // State and output registers; outputs decode the next state so they
  // update on the same edge as present_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lamps_q <= decode_lamps(ST_IDLE);
    end else begin
      state_q <= state_d;
      lamps_q <= decode_lamps(state_d);
    end
  end

  assign present_state = state_q;
  assign y    = lamps_q.y;
  assign v    = lamps_q.v;
  assign r    = lamps_q.r;
  assign a    = lamps_q.a;
  assign vint = lamps_q.vint;
  assign al   = lamps_q.al;
  assign b1   = lamps_q.b1;
  assign b2   = lamps_q.b2;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Directed bench for crossing_sequencer. Main instance uses short phases
// (4/3/2) and T_WDOG=10; a second instance checks a zero-length BLINK.
// Watchdog steps are included when CROSSING_WATCHDOG_EN is defined.
module tb_crossing_sequencer;

  // Expected {y,v,r,a,vint,al,b1,b2} per state, written from the state table
  localparam logic [7:0] O_IDLE   = 8'b0100_0100;
  localparam logic [7:0] O_BLINK  = 8'b0000_1100;
  localparam logic [7:0] O_AMBER  = 8'b0001_0000;
  localparam logic [7:0] O_LOWER  = 8'b0001_0011;
  localparam logic [7:0] O_CLOSED = 8'b0010_0011;
  localparam logic [7:0] O_RAISE  = 8'b1010_0100;
  localparam logic [7:0] O_CLEAR  = 8'b1100_0100;
  localparam logic [7:0] O_FAULT  = 8'b0010_0011;

  localparam logic [3:0] S_IDLE   = 4'b0000;
  localparam logic [3:0] S_BLINK  = 4'b0011;
  localparam logic [3:0] S_AMBER  = 4'b0100;
  localparam logic [3:0] S_LOWER  = 4'b0110;
  localparam logic [3:0] S_CLOSED = 4'b0111;
  localparam logic [3:0] S_RAISE  = 4'b1010;
  localparam logic [3:0] S_CLEAR  = 4'b1011;
  localparam logic [3:0] S_FAULT  = 4'b1111;

  logic       clk = 1'b0;
  logic       rst_n, arrive, depart, bar_down, bar_up;
  logic [3:0] ps, ps0;
  logic       y, v, r, a, vint, al, b1, b2;
  logic       y0, v0, r0, a0, vint0, al0, b10, b20;
  int         tests_run = 0;
  int         fail_cnt = 0;

  // clock
  always #5 clk = ~clk;

  crossing_sequencer #(
    .T_BLINK(16'd4), .T_AMBER(16'd3), .T_CLEAR(16'd2), .T_WDOG(16'd10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arrive(arrive), .depart(depart),
    .bar_down(bar_down), .bar_up(bar_up), .present_state(ps),
    .y(y), .v(v), .r(r), .a(a), .vint(vint), .al(al), .b1(b1), .b2(b2)
  );

  crossing_sequencer #(
    .T_BLINK(16'd0), .T_AMBER(16'd2), .T_CLEAR(16'd1), .T_WDOG(16'd10)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .arrive(arrive), .depart(depart),
    .bar_down(bar_down), .bar_up(bar_up), .present_state(ps0),
    .y(y0), .v(v0), .r(r0), .a(a0), .vint(vint0), .al(al0), .b1(b10), .b2(b20)
  );

  // Advance one clock and sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare main instance state and outputs
  task automatic chk(input string tag, input logic [3:0] st, input logic [7:0] o);
    logic [11:0] obs;
    obs = {ps, y, v, r, a, vint, al, b1, b2};
    tests_run++;
    assert (obs === {st, o}) else begin
      fail_cnt++;
      $error("FAIL %s: state/out got %b/%b expected %b/%b", tag, obs[11:8], obs[7:0], st, o);
    end
  endtask

  // Compare zero-parameter instance state
  task automatic chk0(input string tag, input logic [3:0] st);
    tests_run++;
    assert (ps0 === st) else begin
      fail_cnt++;
      $error("FAIL %s: state got %b expected %b", tag, ps0, st);
    end
  endtask

  // Step n cycles, checking the same expected state each cycle
  task automatic run(input string tag, input int n, input logic [3:0] st, input logic [7:0] o);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, st, o);
    end
  endtask

  initial begin
    rst_n = 1'b0; arrive = 1'b0; depart = 1'b0; bar_down = 1'b0; bar_up = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", S_IDLE, O_IDLE);
    chk0("reset0", S_IDLE);
    rst_n = 1'b1;
    run("idle_hold", 2, S_IDLE, O_IDLE);

    // Test 1: full cycle, with test 3 ignored pulses and test 6 woven in
    arrive = 1'b1;
    step();
    arrive = 1'b0;
    chk("t1_blink", S_BLINK, O_BLINK);
    chk0("t6_blink_first", S_BLINK);
    step();
    chk("t1_blink", S_BLINK, O_BLINK);
    chk0("t6_blink_one_cycle", S_AMBER);
    run("t1_blink", 2, S_BLINK, O_BLINK);
    run("t1_amber", 1, S_AMBER, O_AMBER);
    depart = 1'b1;
    step();
    depart = 1'b0;
    chk("t3_depart_in_amber", S_AMBER, O_AMBER);
    run("t1_amber", 1, S_AMBER, O_AMBER);
    run("t1_lower", 3, S_LOWER, O_LOWER);
    bar_down = 1'b1;
    step();
    bar_down = 1'b0;
    chk("t1_closed", S_CLOSED, O_CLOSED);
    arrive = 1'b1;
    step();
    arrive = 1'b0;
    chk("t3_arrive_in_closed", S_CLOSED, O_CLOSED);
    depart = 1'b1;
    step();
    depart = 1'b0;
    chk("t1_raise", S_RAISE, O_RAISE);
    run("t1_raise_wait", 1, S_RAISE, O_RAISE);
    bar_up = 1'b1;
    step();
    bar_up = 1'b0;
    chk("t1_clear", S_CLEAR, O_CLEAR);
    run("t1_clear", 1, S_CLEAR, O_CLEAR);
    run("t1_idle", 2, S_IDLE, O_IDLE);

    // Test 2: re-arrival during CLEAR, then during RAISE over bar_up
    arrive = 1'b1;
    step();
    arrive = 1'b0;
    chk("t2_blink", S_BLINK, O_BLINK);
    run("t2_blink", 3, S_BLINK, O_BLINK);
    run("t2_amber", 3, S_AMBER, O_AMBER);
    bar_down = 1'b1;
    run("t2_lower", 1, S_LOWER, O_LOWER);
    run("t2_closed", 1, S_CLOSED, O_CLOSED);
    bar_down = 1'b0;
    depart = 1'b1;
    run("t2_raise", 1, S_RAISE, O_RAISE);
    depart = 1'b0;
    bar_up = 1'b1;
    run("t2_clear", 1, S_CLEAR, O_CLEAR);
    bar_up = 1'b0;
    arrive = 1'b1;
    step();
    arrive = 1'b0;
    chk("t2_rearrive_clear", S_LOWER, O_LOWER);
    bar_down = 1'b1;
    run("t2_closed2", 1, S_CLOSED, O_CLOSED);
    bar_down = 1'b0;
    depart = 1'b1;
    run("t2_raise2", 1, S_RAISE, O_RAISE);
    depart = 1'b0;
    arrive = 1'b1;
    bar_up = 1'b1;
    step();
    arrive = 1'b0;
    bar_up = 1'b0;
    chk("t2_rearrive_raise", S_LOWER, O_LOWER);
    bar_down = 1'b1;
    run("t2_closed3", 1, S_CLOSED, O_CLOSED);
    bar_down = 1'b0;

    // Test 4: asynchronous reset in CLOSED, observed before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_reset", S_IDLE, O_IDLE);
    chk0("t4_async_reset0", S_IDLE);
    run("t4_reset_hold", 1, S_IDLE, O_IDLE);
    rst_n = 1'b1;
    run("t4_after_release", 1, S_IDLE, O_IDLE);

`ifdef CROSSING_WATCHDOG_EN
    // Test 5: watchdog expiry in LOWER, then FAULT is sticky
    arrive = 1'b1;
    step();
    arrive = 1'b0;
    chk("t5_blink", S_BLINK, O_BLINK);
    run("t5_blink", 3, S_BLINK, O_BLINK);
    run("t5_amber", 3, S_AMBER, O_AMBER);
    run("t5_lower", 10, S_LOWER, O_LOWER);
    run("t5_fault", 1, S_FAULT, O_FAULT);
    arrive = 1'b1;
    bar_down = 1'b1;
    step();
    arrive = 1'b0;
    bar_down = 1'b0;
    chk("t5_fault_sticky", S_FAULT, O_FAULT);
    rst_n = 1'b0;
    #1;
    chk("t5_fault_reset", S_IDLE, O_IDLE);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
